// File: rtl/cnn_mem_pkg.sv
// Shared types and constants for the CNN dual-port buffer family.
package cnn_mem_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fill_state_t;

    localparam bit PORT_A_WINS = 1'b1;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 5;

endpackage

// File: rtl/cnn_dpram_fill.sv
// Zero-fill sequencer: walks every address once after reset or a clear
// request and holds busy high for the duration of the walk.
module cnn_dpram_fill
    import cnn_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    output logic              fill_we,
    output logic [ADDR_W-1:0] fill_addr
);

    fill_state_t       state_reg;
    logic [ADDR_W-1:0] count_reg;
    logic              busy_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= ST_CLEAR;
            count_reg <= '0;
            busy_reg  <= 1'b1;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    count_reg <= count_reg + 1'b1;
                    // Last address written this edge: ports are live on the next one.
                    if (count_reg == {ADDR_W{1'b1}}) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                        count_reg <= '0;
                    end
                end
                default: begin
                    if (clear) begin
                        state_reg <= ST_CLEAR;
                        busy_reg  <= 1'b1;
                        count_reg <= '0;
                    end
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign fill_we   = busy_reg;
    assign fill_addr = count_reg;

endmodule

// File: rtl/cnn_dpram.sv
// Parametrised single-clock true dual-port RAM with zero-fill, per-port
// read-valid tracking, optional output register and write-collision flag.
module cnn_dpram
    import cnn_mem_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int OUT_REG = 0,
    parameter int RDW_NEW = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    output logic              busy,
    output logic              collision,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic              wren_a,
    input  logic              wren_b,
    input  logic              rden_a,
    input  logic              rden_b,
    output logic [DATA_W-1:0] q_a,
    output logic [DATA_W-1:0] q_b,
    output logic              valid_a,
    output logic              valid_b
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;

    cnn_dpram_fill #(
        .ADDR_W (ADDR_W)
    ) u_fill (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .busy      (busy),
        .fill_we   (fill_we),
        .fill_addr (fill_addr)
    );

    logic [DATA_W-1:0] port_wdata [2];
    logic [ADDR_W-1:0] port_addr  [2];
    logic [1:0]        port_rd;
    logic [1:0]        port_wr;

    assign port_wdata[0] = data_a;
    assign port_wdata[1] = data_b;
    assign port_addr[0]  = address_a;
    assign port_addr[1]  = address_b;
    assign port_rd       = {rden_b, rden_a} & {2{~busy}};
    assign port_wr       = {wren_b, wren_a} & {2{~busy}};

    // The fill sequencer borrows write port A while busy.
    logic              wa_en;
    logic              wb_en;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data;

    always_comb begin
        wa_en   = port_wr[0];
        wa_addr = address_a;
        wa_data = data_a;
        wb_en   = port_wr[1];
        if (fill_we) begin
            wa_en   = 1'b1;
            wa_addr = fill_addr;
            wa_data = '0;
        end
    end

    // Later assignment wins on a same-address double write.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (PORT_A_WINS) begin
                if (wb_en) mem[address_b] <= data_b;
                if (wa_en) mem[wa_addr]   <= wa_data;
            end else begin
                if (wa_en) mem[wa_addr]   <= wa_data;
                if (wb_en) mem[address_b] <= data_b;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [DATA_W-1:0] rd_q_reg;
            logic [DATA_W-1:0] out_q_reg;
            logic              rd_v_reg;
            logic              out_v_reg;
            logic [DATA_W-1:0] q_out;
            logic              v_out;

            // mem read sees pre-write contents; new data is bypassed only on own-port writes.
            always_ff @(posedge clock) begin
                if (reset) begin
                    rd_q_reg  <= '0;
                    out_q_reg <= '0;
                    rd_v_reg  <= 1'b0;
                    out_v_reg <= 1'b0;
                end else begin
                    rd_v_reg  <= port_rd[gi];
                    out_v_reg <= rd_v_reg;
                    if (port_rd[gi]) begin
                        if ((RDW_NEW != 0) && port_wr[gi])
                            rd_q_reg <= port_wdata[gi];
                        else
                            rd_q_reg <= mem[port_addr[gi]];
                    end
                    if (rd_v_reg) out_q_reg <= rd_q_reg;
                end
            end

            assign q_out = (OUT_REG != 0) ? out_q_reg : rd_q_reg;
            assign v_out = (OUT_REG != 0) ? out_v_reg : rd_v_reg;
        end
    endgenerate

    assign q_a     = g_port[0].q_out;
    assign q_b     = g_port[1].q_out;
    assign valid_a = g_port[0].v_out;
    assign valid_b = g_port[1].v_out;

    logic collision_reg;

    always_ff @(posedge clock) begin
        if (reset) collision_reg <= 1'b0;
        else       collision_reg <= port_wr[0] & port_wr[1] & (address_a == address_b);
    end

    assign collision = collision_reg;

endmodule

// File: doc/cnn_dpram.md
# cnn_dpram

Parametrised single-clock true dual-port RAM for CNN feature-map and weight buffering. It is the next generation of the fixed 16×32 dual-port buffer and sits between the layer controllers and the MAC array. It adds a configurable width and depth, an optional output register stage, and a selectable same-port read-during-write mode. It also adds per-port read-valid tracking, a deterministic write-collision policy with a flag, and a hardware zero-fill sequencer run after reset or on request.

## Interface
- DATA_W, 16, word width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- OUT_REG, 0, 1 adds one output register stage on both ports
- RDW_NEW, 1, same-port read-during-write returns new data (1) or old data (0)
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high; one clock, no other clock domains
- clear  in  1  single-cycle request to zero-fill the whole memory
- busy  out  1  zero-fill in progress; port accesses are ignored while high
- collision  out  1  one-cycle pulse: both ports wrote the same address
- data_a / data_b  in  DATA_W  write data
- address_a / address_b  in  ADDR_W  word address
- wren_a / wren_b  in  1  write enable
- rden_a / rden_b  in  1  read request
- q_a / q_b  out  DATA_W  read data
- valid_a / valid_b  out  1  q_x holds the data for a rden_x issued LAT cycles earlier

## Operation
- FSM states: CLEAR and IDLE.
- Reset puts the FSM in CLEAR and sets the fill counter to 0.
- In CLEAR, the block writes 0 to mem[counter] each cycle and increments the counter. When counter = 2**ADDR_W−1 is written, the FSM goes to IDLE. The fill takes exactly 2**ADDR_W cycles.
- In IDLE, clear=1 moves the FSM to CLEAR with the counter at 0.
- clear asserted while in CLEAR is ignored; the fill is not restarted.
- While busy=1, wren_x and rden_x are ignored: no write happens and valid_x stays 0.
- In IDLE, a port with wren=1 writes data_x to mem[address_x] at the clock edge.
- A port with rden=1 reads mem[address_x]. rden and wren may both be set on the same port in the same cycle.
- Same-port read-during-write: with RDW_NEW=1 the port returns data_x; with RDW_NEW=0 it returns the pre-write contents.
- Mixed-port read-during-write (A reads address N while B writes address N, or the reverse): the reading port always returns the old data.
- Both ports writing the same address in the same cycle: port A's data is stored and collision pulses 1 on the next cycle. Each port's own read still follows its RDW rule, using its own write data.
- When rden_x=0, q_x holds its last value.

## Timing
- LAT = 1 + OUT_REG.
- A read request sampled at edge N produces q_x and valid_x=1 after edge N+LAT.
- valid_x is a pure delay line of (rden_x & ~busy), LAT stages deep.
- Reset values: q_a=q_b=0, valid_a=valid_b=0, collision=0, busy=1. busy stays 1 from the reset cycle until the final fill write.
- busy drops in the cycle after the last fill write. The first access is accepted on that same edge.
- When clear is sampled at edge N, busy=1 from N+1.
- Reads already in flight when busy rises still complete, with their valid pulse.
- Reset asserted mid-fill or mid-read clears the pipeline, valid and collision, and restarts the fill from address 0.
- Sustained throughput: one read or write per port per cycle, with no bubbles.

## Structure
- Package cnn_mem_pkg holds:
  - the FSM state type {ST_IDLE, ST_CLEAR};
  - localparams PORT_A_WINS=1 and the default DATA_W and ADDR_W.
- The zero-fill sequencer is the one natural sub-module: cnn_dpram_fill, containing the FSM, the fill counter and busy generation.
- The memory array, RDW mux, output stage and valid pipes stay in the top module.
- Write-port muxing gives the fill write priority over port A.

## Test plan
- Reset, default params: busy=1 for exactly 32 cycles, then 0. Reading all 32 addresses returns 0x0000 each, with valid 1 cycle after each rden.
- Write 0xBEEF at A:7, then read B:7 the next cycle: q_b=0xBEEF with valid_b one cycle later. With OUT_REG=1, the same read lands 2 cycles later.
- Same-port RDW: memory holds 0x1111 at address 3; port A writes 0x2222 and reads address 3 in the same cycle. RDW_NEW=1 gives q_a=0x2222; RDW_NEW=0 gives q_a=0x1111.
- Both ports write address 9, A=0xAAAA and B=0x5555, in the same cycle: collision pulses for one cycle and a later read of address 9 returns 0xAAAA.
- Fill memory with nonzero data, pulse clear, and drive wren_a during the busy window: all writes are dropped, and every address reads 0 after busy falls.
- Assert reset at fill cycle 10 with a read in flight: valid is 0 the next cycle and busy stays 1 for 32 more cycles. With ADDR_W=8, DATA_W=32, the fill takes 256 cycles.
